// File: rtl/button_pkg.sv
// Shared types and constants for the push-button debouncer and its users.
package button_pkg;

  localparam int CLK_FREQ_HZ         = 100_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100;  // 10 ms
  localparam int DEF_LONG_CYCLES     = CLK_FREQ_HZ;        // 1 s
  localparam int DEF_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous bit; reset clears every stage.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes, filters bounce, and emits press/release/long-press pulses.
//
// state           | meaning
// ST_RELEASED     | accepted level 0, input agrees
// ST_PRESS_WAIT   | accepted level 0, counting stable 1 samples
// ST_PRESSED      | accepted level 1, input agrees
// ST_RELEASE_WAIT | accepted level 1, counting stable 0 samples
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("button_debounce: invalid DEBOUNCE_CYCLES/LONG_CYCLES/SYNC_STAGES");
  end

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_CYCLES);
  localparam bit DB_SINGLE = (DEBOUNCE_CYCLES == 1);
  // The transition out of a stable state consumes the first agreeing sample,
  // so the wait state accepts when the count is two short of the target.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

  logic              w_s;
  btn_state_t        r_state, w_state_nxt;
  logic [DB_W-1:0]   r_db_cnt, w_db_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic              r_level, r_press, r_release, r_long;
  logic              w_press_nxt, w_release_nxt, w_long_nxt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (btn_in),
    .o_q     (w_s)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_db_nxt      = r_db_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    unique case (r_state)
      ST_RELEASED: begin
        if (w_s) begin
          w_db_nxt = '0;
          if (DB_SINGLE) begin
            w_state_nxt = ST_PRESSED;
            w_press_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_PRESS_WAIT;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASED;
          w_db_nxt    = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_db_nxt    = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_db_nxt = r_db_cnt + DB_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!w_s) begin
          w_db_nxt = '0;
          if (DB_SINGLE) begin
            w_state_nxt   = ST_RELEASED;
            w_release_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RELEASE_WAIT;
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = ST_PRESSED;
          w_db_nxt    = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt   = ST_RELEASED;
          w_db_nxt      = '0;
          w_release_nxt = 1'b1;
        end else begin
          w_db_nxt = r_db_cnt + DB_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_db_nxt    = '0;
      end
    endcase
  end

  // Hold time runs from the accepted press and parks at its last value.
  always_comb begin
    w_hold_nxt = r_hold_cnt;
    w_long_nxt = 1'b0;
    if (w_press_nxt) begin
      w_hold_nxt = '0;
    end else if (r_level && (r_hold_cnt != HOLD_LAST)) begin
      w_hold_nxt = r_hold_cnt + HOLD_W'(1);
      w_long_nxt = (r_hold_cnt == HOLD_PRE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RELEASED;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_db_cnt   <= w_db_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_level    <= (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
      r_press    <= w_press_nxt;
      r_release  <= w_release_nxt;
      r_long     <= w_long_nxt;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_long    = r_long;

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, the number of consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 100_000_000, the number of cycles held pressed, counted from the accepted press, before a long-press event (1 s).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, the depth of the input synchronizer.
REQ-004 The block SHALL have port clk  input  1  100 MHz system clock; all logic on rising edge.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port btn_in  input  1  raw asynchronous push-button, active high, bouncing.
REQ-007 The block SHALL have port btn_level  output  1  debounced button level.
REQ-008 The block SHALL have port btn_press  output  1  one-cycle pulse on accepted press.
REQ-009 The block SHALL have port btn_release  output  1  one-cycle pulse on accepted release.
REQ-010 The block SHALL have port btn_long  output  1  one-cycle pulse on long press.

Function
REQ-011 btn_in SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (s) feeds further logic.
REQ-012 The FSM SHALL have states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-013 In RELEASED, s=1 SHALL move to PRESS_WAIT with the debounce counter cleared to 0.
REQ-014 In PRESS_WAIT, s=1 SHALL increment the counter; s=0 SHALL return to RELEASED; when s=1 and the counter equals DEBOUNCE_CYCLES-1 the FSM SHALL enter PRESSED.
REQ-015 PRESSED/RELEASE_WAIT SHALL mirror REQ-013/014 with s polarity inverted, returning to RELEASED on acceptance.
REQ-016 btn_level SHALL be 1 exactly in states PRESSED and RELEASE_WAIT (registered, glitch-free).
REQ-017 Accept latency SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES clock edges from the first edge that samples a steady new btn_in value to the edge at which btn_level changes.
REQ-018 btn_press and btn_release SHALL be registered and SHALL assert for exactly one cycle, coincident with the first cycle of the new btn_level value.
REQ-019 Any bounce (s reverting) before acceptance SHALL discard the partial count; no pulse, no btn_level change.
REQ-020 A hold counter SHALL clear on entry to PRESSED and count every cycle btn_level=1, including RELEASE_WAIT.
REQ-021 btn_long SHALL pulse once when the hold counter reaches LONG_CYCLES-1; it SHALL saturate and not repeat until the next accepted press.
REQ-022 Release accepted before LONG_CYCLES SHALL produce no btn_long.
REQ-023 Counter widths SHALL be $clog2 of the respective parameter, minimum 1 bit; no counter SHALL wrap.
REQ-024 DEBOUNCE_CYCLES < 1, SYNC_STAGES < 2 or LONG_CYCLES <= DEBOUNCE_CYCLES SHALL be rejected at elaboration.

Reset
REQ-025 reset_n low SHALL asynchronously force: state RELEASED, all counters 0, synchronizer flops 0, btn_level/btn_press/btn_release/btn_long 0.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL abort with no pulse; a button still held at reset release SHALL be re-accepted as a new press after full REQ-017 latency.

Structure
REQ-027 Package button_pkg SHALL hold the state enum typedef and constants CLK_FREQ_HZ = 100_000_000 and default cycle counts.
REQ-028 The synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, async active-low reset), reusable by other blocks.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, SYNC_STAGES=2)
REQ-029 Clean press: btn_in 0->1 held -> btn_level rises 6 edges later, btn_press high for exactly 1 cycle at that edge.
REQ-030 Bounce: btn_in high 3 cycles, low 1, high steady -> no pulse during bounce; btn_level rises 6 edges after final rise.
REQ-031 Long press: hold 30 cycles after acceptance -> single btn_long 19 cycles after btn_press, none afterwards; release -> btn_release once.
REQ-032 Short press: hold 10 cycles then release -> btn_press and btn_release once each, no btn_long.
REQ-033 Reset mid-hold: assert reset_n low at hold count 10 while btn_in=1 -> all outputs 0 immediately; after release, btn_press again 6 edges later.
REQ-034 Glitch train: 1-cycle pulses on btn_in every 2 cycles for 50 cycles -> btn_level stays 0, no pulses.
